// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared funct codes, mul/div FSM state type and helpers for
//               the EX-stage HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MTHI) || (f == FN_MFLO) || (f == FN_MTLO) ||
           is_muldiv(f);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : ID/EX-side bundle for the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_unit_if #(
  parameter int WIDTH = mips_pkg::WIDTH_DEF
);
  logic             valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hilo_rd;

  modport master (
    output valid, funct, opA, opB, flush,
    input  stall, busy, done, div_by_zero, hilo_rd
  );

  modport slave (
    input  valid, funct, opA, opB, flush,
    output stall, busy, done, div_by_zero, hilo_rd
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration: shift-add multiply or restoring divide
//               on the {acc, mq} working pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] mq_nx
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    shifted = {acc, mq[WIDTH-1]};
    // remainder < divisor keeps a non-borrowing diff below 2**WIDTH
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      acc_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      mq_nx  = {mq[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_nx = sum[WIDTH:1];
      mq_nx  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU into HI/LO plus MFHI/MFLO/MTHI/
//               MTLO; stalls ID/EX while busy. MULDIV_FAST_MULT_EN selects a
//               single-cycle registered multiplier for MULT/MULTU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic               Clk,
  input  logic               Rst_n,
  ex_muldiv_unit_if.slave    bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   acc_nx, mq_nx, a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic               sgn_op, sa, sb, busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc    (acc_q),
    .mq     (mq_q),
    .opnd   (opnd_q),
    .acc_nx (acc_nx),
    .mq_nx  (mq_nx)
  );

`ifdef MULDIV_FAST_MULT_EN
  assign prod_raw = (2*WIDTH)'(mq_q) * (2*WIDTH)'(opnd_q);
`else
  assign prod_raw = {acc_q, mq_q};
`endif

  assign sgn_op   = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
  assign sa       = sgn_op & bus.opA[WIDTH-1];
  assign sb       = sgn_op & bus.opB[WIDTH-1];
  assign a_abs    = sa ? -bus.opA : bus.opA;
  assign b_abs    = sb ? -bus.opB : bus.opB;
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
  assign quo_fix  = dz_q ? '1 : (neg_res_q ? -mq_q : mq_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  assign busy             = (state_q != IDLE);
  assign bus.busy         = busy;
  assign bus.stall        = bus.valid & busy & is_hilo(bus.funct);
  assign bus.done         = done_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.hilo_rd      = (bus.valid && !bus.stall && bus.funct == FN_MFHI) ? hi_q :
                            (bus.valid && !bus.stall && bus.funct == FN_MFLO) ? lo_q : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid && !bus.flush) begin
          if (is_muldiv(bus.funct)) begin
            acc_d     = '0;
            mq_d      = a_abs;
            opnd_d    = b_abs;
            is_div_d  = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
            neg_res_d = sa ^ sb;
            neg_rem_d = sa;
            dz_d      = (bus.opB == '0);
            cnt_d     = '0;
            state_d   = RUN;
`ifdef MULDIV_FAST_MULT_EN
            if (!is_div_d) state_d = FIX;
`endif
          end else if (bus.funct == FN_MTHI) begin
            hi_d = bus.opA;
          end else if (bus.funct == FN_MTLO) begin
            lo_d = bus.opA;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_nx;
          mq_d  = mq_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d  = rem_fix;
            lo_d  = quo_fix;
            dbz_d = dz_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Scoreboard bench for ex_muldiv_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
  import mips_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  typedef struct {
    logic dbz;
    int   blen;
  } done_t;

  logic Clk = 1'b0;
  logic Rst_n;
  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int          vectors = 0;
  int          miscompares = 0;
  done_t       exp_done[$];
  logic [31:0] exp_rd[$];
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge Clk) begin
    if (!Rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.div_by_zero && !bus.done) chk("dbz_without_done", 32'd1, 32'd0);
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
          chk("busy_cycles", busy_cnt, e.blen);
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
      if (bus.valid && !bus.stall && (bus.funct == FN_MFHI || bus.funct == FN_MFLO)) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk(bus.funct == FN_MFHI ? "mfhi" : "mflo", bus.hilo_rd, exp_rd.pop_front());
      end
    end
  end

  // Presents one instruction; returns how many cycles it was stalled
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int waits);
    bus.valid = 1'b1;
    bus.funct = f;
    bus.opA   = a;
    bus.opB   = b;
    waits     = 0;
    forever begin
      @(negedge Clk);
      if (!bus.stall) break;
      waits++;
      if (waits > 200) begin
        chk("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge Clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic dbz, input int blen);
    int w;
    done_t e;
    e.dbz = dbz;
    e.blen = blen;
    exp_done.push_back(e);
    issue(f, a, b, w);
  endtask

  task automatic mf(input logic [5:0] f, input logic [31:0] exp);
    int w;
    exp_rd.push_back(exp);
    issue(f, 32'd0, 32'd0, w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    Rst_n     = 1'b0;
    bus.valid = 1'b0;
    bus.funct = 6'h00;
    bus.opA   = '0;
    bus.opB   = '0;
    bus.flush = 1'b0;
    idle(3);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    idle(1);
    mf(FN_MFHI, 32'h0);
    mf(FN_MFLO, 32'h0);

    // signed multiply 7 * -3
    op(FN_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, MUL_BUSY);
    mf(FN_MFHI, 32'hFFFF_FFFF);
    mf(FN_MFLO, 32'hFFFF_FFEB);

    // unsigned divide; an unrelated funct must not stall meanwhile
    op(FN_DIVU, 32'd100, 32'd7, 1'b0, DIV_BUSY);
    issue(6'h20, 32'd1, 32'd2, w);
    chk("non_hilo_stall", w, 0);
    mf(FN_MFLO, 32'd14);
    mf(FN_MFHI, 32'd2);

    op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_BUSY);
    mf(FN_MFLO, 32'hFFFF_FFFD);
    mf(FN_MFHI, 32'hFFFF_FFFF);

    op(FN_DIV, 32'd5, 32'd0, 1'b1, DIV_BUSY);
    mf(FN_MFLO, 32'hFFFF_FFFF);
    mf(FN_MFHI, 32'd5);

    op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_BUSY);
    mf(FN_MFLO, 32'h8000_0000);
    mf(FN_MFHI, 32'h0);

    op(FN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_BUSY);
    mf(FN_MFLO, 32'h0);
    mf(FN_MFHI, 32'h8000_0000);

    issue(FN_MTHI, 32'h1234_5678, 32'd0, w);
    mf(FN_MFHI, 32'h1234_5678);

    // MFLO two cycles after MULTU stalls until the result lands
    op(FN_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MUL_BUSY);
    idle(1);
    exp_rd.push_back(32'hFFFF_FFFE);
    issue(FN_MFLO, 32'd0, 32'd0, w);
    chk("mflo_stall_cycles", w, MUL_BUSY - 1);
    mf(FN_MFHI, 32'd1);

    // back-to-back multiplies
    op(FN_MULT, 32'd3, 32'd5, 1'b0, MUL_BUSY);
    exp_done.push_back('{dbz: 1'b0, blen: MUL_BUSY});
    issue(FN_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFC, w);
    chk("b2b_stall_cycles", w, MUL_BUSY);
    mf(FN_MFLO, 32'd8);
    mf(FN_MFHI, 32'd0);

    // flush mid-division keeps HI/LO
    issue(FN_MTHI, 32'h1111_1111, 32'd0, w);
    issue(FN_MTLO, 32'h2222_2222, 32'd0, w);
    issue(FN_DIVU, 32'd100, 32'd7, w);
    idle(9);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    @(negedge Clk);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    idle(1);
    mf(FN_MFHI, 32'h1111_1111);
    mf(FN_MFLO, 32'h2222_2222);

    // reset mid-multiply clears HI/LO
    issue(FN_MTLO, 32'h0000_AAAA, 32'd0, w);
    issue(FN_MULT, 32'd3, 32'd3, w);
    idle(9);
    Rst_n = 1'b0;
    idle(1);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    idle(1);
    mf(FN_MFLO, 32'h0);
    mf(FN_MFHI, 32'h0);

    idle(40);
    chk("pending_done", exp_done.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
